// File: rtl/game_tick_ctrl.sv
// Game tick controller: divides the system clock into game ticks whose period
// is BASE_DIV * 2^cur_rate cycles, with run/pause/stop control, a one-deep
// manual rate request slot and an optional automatic speed-up every
// LEVEL_TICKS ticks.
//
// Rate request handshake: a request is taken on any cycle where
// rate_req_valid && rate_req_ready; rate_req_ready is low exactly while a taken
// request is pending, and rises the cycle after that request has been applied.
module game_tick_ctrl #(
    parameter int unsigned BASE_DIV    = 12500,
    parameter int unsigned LEVEL_TICKS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        pause,
    input  logic        auto_en,
    input  logic        rate_req_valid,
    input  logic [1:0]  rate_req,
    output logic        rate_req_ready,
    output logic        tick,
    output logic        clk_game,
    output logic [1:0]  cur_rate,
    output logic        running,
    output logic [15:0] tick_count,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] cnt;
    logic [31:0] level_cnt;
    logic        pend_valid;
    logic [1:0]  pend_rate;
    logic        tick_q;

    logic [31:0] period_last;
    logic        advance;
    logic        wrap;
    logic        accept;
    logic        apply_manual;
    logic        level_hit;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the per-cycle control decisions of the datapath.
    // The counter only advances when RUN is kept for the next cycle, so a
    // wrap coinciding with stop or pause neither issues a tick nor loses one.
    always_comb begin
        state_next   = state;
        period_last  = (32'(BASE_DIV) << cur_rate) - 32'd1;
        advance      = 1'b0;
        wrap         = 1'b0;
        accept       = 1'b0;
        apply_manual = 1'b0;
        level_hit    = 1'b0;

        if (stop) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start)  state_next = RUN;
                RUN:     if (pause)  state_next = PAUSED;
                PAUSED:  if (!pause) state_next = RUN;
                default: state_next = IDLE;
            endcase
        end

        advance      = (state == RUN) && (state_next == RUN);
        wrap         = advance && (cnt == period_last);
        accept       = rate_req_valid && !pend_valid;
        // In RUN a new rate waits for a period boundary; elsewhere it lands at once.
        apply_manual = pend_valid && ((state == RUN) ? wrap : 1'b1);
        level_hit    = (level_cnt == 32'(LEVEL_TICKS - 1));
    end

    // Cycle counter, tick generation, rate selection and request slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= 32'd0;
            level_cnt  <= 32'd0;
            pend_valid <= 1'b0;
            pend_rate  <= 2'd0;
            cur_rate   <= 2'b10;
            clk_game   <= 1'b0;
            tick_q     <= 1'b0;
            tick_count <= 16'd0;
        end else begin
            tick_q <= wrap;

            if (accept) begin
                pend_valid <= 1'b1;
                pend_rate  <= rate_req;
            end

            if (state_next == IDLE) begin
                cnt        <= 32'd0;
                tick_count <= 16'd0;
                level_cnt  <= 32'd0;
            end else if (advance) begin
                if (wrap) begin
                    cnt        <= 32'd0;
                    clk_game   <= ~clk_game;
                    tick_count <= tick_count + 16'd1;
                end else begin
                    cnt <= cnt + 32'd1;
                end
            end

            // Manual apply wins over an auto step on the same boundary.
            if (apply_manual) begin
                cur_rate   <= pend_rate;
                pend_valid <= 1'b0;
                level_cnt  <= 32'd0;
            end else if (wrap && auto_en) begin
                if (level_hit) begin
                    level_cnt <= 32'd0;
                    if (cur_rate != 2'd0) begin
                        cur_rate <= cur_rate - 2'd1;
                    end
                end else begin
                    level_cnt <= level_cnt + 32'd1;
                end
            end
        end
    end

    // Output decode.
    always_comb begin
        tick           = tick_q && (state == RUN);
        running        = (state == RUN);
        rate_req_ready = !pend_valid;
        fsm_state      = state;
    end

endmodule

// File: tb/tb_game_tick_ctrl.sv
// Directed bench for game_tick_ctrl with BASE_DIV=4, LEVEL_TICKS=3.
module tb_game_tick_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic        pause;
  logic        auto_en;
  logic        rate_req_valid;
  logic [1:0]  rate_req;
  logic        rate_req_ready;
  logic        tick;
  logic        clk_game;
  logic [1:0]  cur_rate;
  logic        running;
  logic [15:0] tick_count;
  logic [1:0]  fsm_state;

  int checks = 0;
  int errors = 0;
  int exp_tc = 0;
  logic exp_cg = 1'b0;

  game_tick_ctrl #(.BASE_DIV(4), .LEVEL_TICKS(3)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .auto_en(auto_en), .rate_req_valid(rate_req_valid), .rate_req(rate_req),
    .rate_req_ready(rate_req_ready), .tick(tick), .clk_game(clk_game),
    .cur_rate(cur_rate), .running(running), .tick_count(tick_count),
    .fsm_state(fsm_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the next tick and checks its spacing plus the
  // tick_count / clk_game model.
  task automatic wait_tick(input string tag, input int exp_n);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 200) begin
      cyc(1);
      n++;
      if (tick === 1'b1) seen = 1'b1;
    end
    if (!seen) n = -1;
    check({tag, "_gap"}, 32'(n), 32'(exp_n));
    if (seen) begin
      exp_tc++;
      exp_cg = ~exp_cg;
    end
    check({tag, "_count"}, 32'(tick_count), 32'(exp_tc));
    check({tag, "_clk_game"}, 32'(clk_game), 32'(exp_cg));
  endtask

  task automatic request(input logic [1:0] r);
    rate_req_valid = 1'b1;
    rate_req = r;
    cyc(1);
    rate_req_valid = 1'b0;
  endtask

  initial begin
    int ticks_seen;
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; auto_en = 1'b0;
    rate_req_valid = 1'b0; rate_req = 2'd0;

    // reset values
    cyc(2);
    check("rst_tick", 32'(tick), 0);
    check("rst_clk_game", 32'(clk_game), 0);
    check("rst_rate", 32'(cur_rate), 2);
    check("rst_ready", 32'(rate_req_ready), 1);
    check("rst_running", 32'(running), 0);
    check("rst_count", 32'(tick_count), 0);
    rst = 1'b0;
    cyc(1);

    // start: ticks every 16 cycles at rate 2
    start = 1'b1; cyc(1); start = 1'b0;
    check("start_running", 32'(running), 1);
    wait_tick("run_t1", 16);
    wait_tick("run_t2", 16);
    wait_tick("run_t3", 16);

    // manual request rate 0 mid-period; current period finishes at 16
    cyc(5);                      // cnt = 5
    request(2'd0);               // accepted, cnt = 6
    check("req_ready_low", 32'(rate_req_ready), 0);
    check("req_rate_hold", 32'(cur_rate), 2);
    wait_tick("req_boundary", 10);
    check("req_applied", 32'(cur_rate), 0);
    check("req_ready_high", 32'(rate_req_ready), 1);
    wait_tick("fast_t1", 4);
    wait_tick("fast_t2", 4);

    // back to rate 2, then auto speed-up
    request(2'd2);
    wait_tick("back_to2", 3);
    check("back_rate", 32'(cur_rate), 2);
    auto_en = 1'b1;
    wait_tick("auto_a1", 16);
    wait_tick("auto_a2", 16);
    check("auto_rate2_held", 32'(cur_rate), 2);
    wait_tick("auto_a3", 16);
    check("auto_rate1", 32'(cur_rate), 1);
    wait_tick("auto_b1", 8);
    wait_tick("auto_b2", 8);
    wait_tick("auto_b3", 8);
    check("auto_rate0", 32'(cur_rate), 0);
    wait_tick("auto_c1", 4);
    wait_tick("auto_c2", 4);
    wait_tick("auto_c3", 4);
    check("auto_sat0", 32'(cur_rate), 0);

    // manual rate 3 collides with an auto step
    wait_tick("coll_t1", 4);
    wait_tick("coll_t2", 4);
    request(2'd3);
    wait_tick("coll_boundary", 3);
    check("coll_manual_wins", 32'(cur_rate), 3);
    wait_tick("coll_after1", 32);
    wait_tick("coll_after2", 32);
    check("coll_level_cleared", 32'(cur_rate), 3);
    wait_tick("coll_after3", 32);
    check("coll_auto_next", 32'(cur_rate), 2);
    auto_en = 1'b0;

    // pause at cnt = 5 for 20 cycles
    cyc(5);
    pause = 1'b1;
    ticks_seen = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (tick === 1'b1) ticks_seen++;
    end
    check("pause_no_ticks", 32'(ticks_seen), 0);
    check("pause_not_running", 32'(running), 0);
    check("pause_count_frozen", 32'(tick_count), 32'(exp_tc));
    pause = 1'b0;
    cyc(1);
    check("resume_running", 32'(running), 1);
    wait_tick("resume", 11);

    // stop, IDLE-side behaviour
    cyc(3);
    stop = 1'b1; cyc(1); stop = 1'b0;
    exp_tc = 0;
    check("stop_running", 32'(running), 0);
    check("stop_count_clear", 32'(tick_count), 0);
    check("stop_clk_game_hold", 32'(clk_game), 32'(exp_cg));
    check("stop_rate_hold", 32'(cur_rate), 2);
    request(2'd1);
    check("idle_req_ready_low", 32'(rate_req_ready), 0);
    cyc(1);
    check("idle_req_applied", 32'(cur_rate), 1);
    check("idle_req_ready_high", 32'(rate_req_ready), 1);
    pause = 1'b1; cyc(2); pause = 1'b0;
    check("idle_pause_ignored", 32'(fsm_state), 0);
    start = 1'b1; cyc(1); start = 1'b0;
    check("restart_running", 32'(running), 1);
    wait_tick("restart", 8);

    // stop on the wrap cycle: no tick
    cyc(7);                      // cnt = 7 = last count at rate 1
    stop = 1'b1; cyc(1); stop = 1'b0;
    exp_tc = 0;
    check("stopwrap_tick", 32'(tick), 0);
    check("stopwrap_running", 32'(running), 0);
    check("stopwrap_count", 32'(tick_count), 0);
    check("stopwrap_clk_game", 32'(clk_game), 32'(exp_cg));

    // reset with a pending request mid-RUN
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(3);
    request(2'd3);
    check("pre_rst_ready", 32'(rate_req_ready), 0);
    rst = 1'b1; cyc(1);
    exp_tc = 0; exp_cg = 1'b0;
    check("mid_rst_ready", 32'(rate_req_ready), 1);
    check("mid_rst_rate", 32'(cur_rate), 2);
    check("mid_rst_running", 32'(running), 0);
    check("mid_rst_count", 32'(tick_count), 0);
    check("mid_rst_clk_game", 32'(clk_game), 0);
    check("mid_rst_tick", 32'(tick), 0);
    rst = 1'b0;
    start = 1'b1; cyc(1); start = 1'b0;
    wait_tick("post_rst", 16);
    check("post_rst_rate", 32'(cur_rate), 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
